// File: rtl/kernel_pack.sv
// Packs narrow upstream beats into wide kernel words and feeds them to the kernel memory.
// Define KERNEL_PACK_MSB_FIRST_EN to place the first beat of each word in the MSBs.
module kernel_pack #(
  parameter int unsigned GROUP_NB   = 4,
  parameter int unsigned KER_WIDTH  = 16,
  parameter int unsigned DEPTH_NB   = 16,
  parameter int unsigned UP_WIDTH   = 64,
  parameter int unsigned MEM_AWIDTH = 16,
  localparam int unsigned W         = GROUP_NB * KER_WIDTH * DEPTH_NB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] cfg_words,
  input  logic                  cfg_set,
  input  logic [UP_WIDTH-1:0]   up_data,
  input  logic                  up_val,
  output logic                  up_rdy,
  output logic [W-1:0]          wr_data,
  output logic                  wr_data_val,
  input  logic                  wr_data_rdy,
  output logic [MEM_AWIDTH-1:0] wr_cfg_end,
  output logic                  wr_cfg_set,
  output logic                  busy
);

  localparam int unsigned BEATS = W / UP_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CFG   = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [MEM_AWIDTH-1:0] words_q, wr_base_q, word_cnt_q, word_cnt_inc;
  logic [MEM_AWIDTH-1:0] cfg_end_q;
  logic                  cfg_set_q;
  logic [BW-1:0]         beat_cnt_q, slot;
  logic [W-1:0]          pack_q, pack_d, out_q;
  logic                  val_q;
  logic                  last_beat, accept, word_done, cfg_take;

  always_comb begin
    last_beat    = (beat_cnt_q == LAST_BEAT);
    // Only the final beat has to wait for the output register to free up.
    up_rdy       = (state_q == LOAD) && !(last_beat && val_q && !wr_data_rdy);
    accept       = up_val && up_rdy;
    word_done    = accept && last_beat;
    word_cnt_inc = word_cnt_q + MEM_AWIDTH'(1);
    cfg_take     = (state_q == IDLE) && cfg_set && (cfg_words != '0);
`ifdef KERNEL_PACK_MSB_FIRST_EN
    slot = LAST_BEAT - beat_cnt_q;
`else
    slot = beat_cnt_q;
`endif
    pack_d = pack_q;
    if (accept) begin
      pack_d[slot*UP_WIDTH +: UP_WIDTH] = up_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_take) state_d = CFG;
      CFG:     state_d = LOAD;
      LOAD:    if (word_done && (word_cnt_inc == words_q)) state_d = DRAIN;
      DRAIN:   if (!val_q || wr_data_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      words_q    <= '0;
      wr_base_q  <= '0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      cfg_end_q  <= '0;
      cfg_set_q  <= 1'b0;
      pack_q     <= '0;
      out_q      <= '0;
      val_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_set_q <= 1'b0;
      if (cfg_take) begin
        words_q   <= cfg_words;
        cfg_end_q <= wr_base_q + cfg_words - MEM_AWIDTH'(1);
        cfg_set_q <= 1'b1;
      end
      if (state_q == CFG) begin
        wr_base_q  <= wr_base_q + words_q;
        word_cnt_q <= '0;
        beat_cnt_q <= '0;
      end
      if (accept) begin
        pack_q     <= pack_d;
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BW'(1);
      end
      if (word_done) begin
        out_q      <= pack_d;
        val_q      <= 1'b1;
        word_cnt_q <= word_cnt_inc;
      end else if (val_q && wr_data_rdy) begin
        val_q <= 1'b0;
      end
    end
  end

  assign wr_data     = out_q;
  assign wr_data_val = val_q;
  assign wr_cfg_end  = cfg_end_q;
  assign wr_cfg_set  = cfg_set_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_kernel_pack.sv
// Bench for kernel_pack: load table plus hand-written stall, ignore and reset sequences.
// Memory address width is narrowed so address wrap is reachable in a short run.
module tb_kernel_pack;
  localparam int unsigned UPW   = 64;
  localparam int unsigned W     = 1024;
  localparam int unsigned BEATS = W / UPW;
  localparam int unsigned MAW   = 4;
  localparam int unsigned DEPTH = 1 << MAW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [MAW-1:0] cfg_words = '0;
  logic           cfg_set = 1'b0;
  logic [UPW-1:0] up_data = '0;
  logic           up_val = 1'b0;
  logic           up_rdy;
  logic [W-1:0]   wr_data;
  logic           wr_data_val;
  logic           wr_data_rdy = 1'b0;
  logic [MAW-1:0] wr_cfg_end;
  logic           wr_cfg_set;
  logic           busy;

  kernel_pack #(.MEM_AWIDTH(MAW)) dut (
    .clk(clk), .rst(rst), .cfg_words(cfg_words), .cfg_set(cfg_set),
    .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .wr_data(wr_data), .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy),
    .wr_cfg_end(wr_cfg_end), .wr_cfg_set(wr_cfg_set), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int words;
    int val_pct;
    int rdy_pct;
    bit seq;
    int exp_end;
  } load_t;
  load_t tbl[6];

  int vecs = 0;
  int errs = 0;
  int model_base = 0;

  // Reference model state, written only by the monitor.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur = '0;
  logic [W-1:0] held = '0;
  int beat_k = 0;
  int acc_cnt = 0;
  int words_out = 0;
  int last_hs_cyc = 0;
  bit stalled = 0;
  bit chk_val = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_word(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      for (int k = 0; k < BEATS; k++) begin
        if (act[k*UPW +: UPW] !== expv[k*UPW +: UPW]) begin
          $display("FAIL %s: slice %0d got %h, want %h (t=%0t)", nm, k,
                   act[k*UPW +: UPW], expv[k*UPW +: UPW], $time);
          break;
        end
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        cur = '0;
        beat_k = 0;
        stalled = 0;
        chk_val = 0;
      end else begin
        if (chk_val) chk("val_after_last_beat", wr_data_val, 1);
        chk_val = 0;
        if (stalled) begin
          chk("stall_val_hold", wr_data_val, 1);
          chk_word("stall_data_hold", wr_data, held);
        end
        stalled = wr_data_val && !wr_data_rdy;
        held = wr_data;
        if (wr_data_val && wr_data_rdy) begin
          if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL extra_word: got a word, want none (t=%0t)", $time);
          end else begin
            chk_word("word", wr_data, exp_q.pop_front());
          end
          words_out++;
          last_hs_cyc = cyc;
        end
        if (up_val && up_rdy) begin
`ifdef KERNEL_PACK_MSB_FIRST_EN
          cur = {cur[W-UPW-1:0], up_data};
`else
          cur = {up_data, cur[W-1:UPW]};
`endif
          beat_k++;
          acc_cnt++;
          if (beat_k == BEATS) begin
            exp_q.push_back(cur);
            beat_k = 0;
            chk_val = 1;
          end
        end
      end
    end
  endtask

  task automatic drive_cycle(input int val_pct, input int rdy_pct, input bit seq, input int base);
    up_val = ($urandom_range(99) < val_pct);
    up_data = seq ? UPW'(acc_cnt - base) : {$urandom, $urandom};
    wr_data_rdy = ($urandom_range(99) < rdy_pct);
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int words, input int exp_end);
    cfg_words = MAW'(words);
    cfg_set = 1'b1;
    @(posedge clk);
    #1;
    cfg_set = 1'b0;
    chk("cfg_set_pulse", wr_cfg_set, 1);
    chk("cfg_end", wr_cfg_end, exp_end);
    chk("busy_in_cfg", busy, 1);
    model_base = (model_base + words) % DEPTH;
  endtask

  task automatic stream(input int nbeats, input int val_pct, input int rdy_pct, input bit seq,
                        input int base, output int iters);
    iters = 0;
    while (acc_cnt < base + nbeats && iters < 20000) begin
      drive_cycle(val_pct, rdy_pct, seq, base);
      iters++;
    end
    chk("beats_accepted", acc_cnt - base, nbeats);
    up_val = 1'b0;
  endtask

  task automatic finish_load(input int rdy_pct, input int words, input int wo_base);
    int n = 0;
    up_val = 1'b0;
    while (busy && n < 2000) begin
      wr_data_rdy = ($urandom_range(99) < rdy_pct);
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_fall", busy, 0);
    chk("busy_fall_cycle", cyc, last_hs_cyc + 1);
    chk("words_out", words_out - wo_base, words);
    chk("model_queue_empty", exp_q.size(), 0);
    chk("val_idle", wr_data_val, 0);
    chk("up_rdy_idle", up_rdy, 0);
  endtask

  task automatic main_seq();
    int b, wo, it, exp_end;
    tbl[0] = '{3, 100, 100, 1'b1, 2};
    tbl[1] = '{2, 100, 100, 1'b0, 4};
    tbl[2] = '{9, 70, 60, 1'b0, 13};
    tbl[3] = '{4, 100, 100, 1'b0, 1};   // crosses the top of the address space
    tbl[4] = '{1, 50, 40, 1'b0, 2};
    tbl[5] = '{5, 80, 30, 1'b0, 7};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_up_rdy", up_rdy, 0);
    chk("rst_val", wr_data_val, 0);
    chk_word("rst_data", wr_data, '0);
    chk("rst_cfg_end", wr_cfg_end, 0);
    chk("rst_cfg_set", wr_cfg_set, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      b = acc_cnt;
      wo = words_out;
      start_load(tbl[i].words, tbl[i].exp_end);
      stream(tbl[i].words * BEATS, tbl[i].val_pct, tbl[i].rdy_pct, tbl[i].seq, b, it);
      // One CFG cycle, then one beat per cycle with no bubbles.
      if (i == 0) chk("no_bubbles", it, tbl[i].words * BEATS + 1);
      finish_load(tbl[i].rdy_pct, tbl[i].words, wo);
    end

    // Back-pressure: a stalled word lets only BEATS-1 further beats in.
    b = acc_cnt;
    wo = words_out;
    exp_end = (model_base + 1) % DEPTH;
    start_load(2, exp_end);
    for (int c = 0; c < 40; c++) drive_cycle(100, 0, 1'b0, b);
    chk("stall_beats", acc_cnt - b, 2 * BEATS - 1);
    chk("stall_up_rdy", up_rdy, 0);
    chk("stall_val", wr_data_val, 1);
    if (exp_q.size() > 0) chk_word("stall_word", wr_data, exp_q[0]);
    up_val = 1'b0;
    cfg_words = MAW'(5);
    cfg_set = 1'b1;
    @(posedge clk);
    #1;
    cfg_set = 1'b0;
    chk("cfg_set_in_load_ignored", wr_cfg_set, 0);
    chk("cfg_end_unchanged", wr_cfg_end, exp_end);
    chk("busy_in_load", busy, 1);
    stream(2 * BEATS, 100, 100, 1'b0, b, it);
    finish_load(100, 2, wo);

    // Zero-length configuration must be ignored.
    cfg_words = '0;
    cfg_set = 1'b1;
    @(posedge clk);
    #1;
    cfg_set = 1'b0;
    chk("zero_words_no_pulse", wr_cfg_set, 0);
    chk("zero_words_idle", busy, 0);
    @(posedge clk);
    #1;
    chk("zero_words_still_idle", busy, 0);

    // Reset mid-load, after one word has already gone out.
    b = acc_cnt;
    start_load(2, (model_base + 1) % DEPTH);
    for (int c = 0; c < BEATS + 5; c++) drive_cycle(100, 100, 1'b0, b);
    rst = 1'b0;
    up_val = 1'b0;
    model_base = 0;
    @(posedge clk);
    #1;
    chk("midrst_up_rdy", up_rdy, 0);
    chk("midrst_val", wr_data_val, 0);
    chk_word("midrst_data", wr_data, '0);
    chk("midrst_cfg_end", wr_cfg_end, 0);
    chk("midrst_cfg_set", wr_cfg_set, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    b = acc_cnt;
    wo = words_out;
    start_load(2, 1);
    stream(2 * BEATS, 100, 100, 1'b1, b, it);
    finish_load(100, 2, wo);
  endtask

  initial begin
    fork
      main_seq();
      monitor();
      begin
        #5_000_000;
        errs++;
        $display("FAIL watchdog: simulation time limit reached");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/kernel_pack.md
# kernel_pack

Upstream feeder for the kernel memory. Accepts kernel and bias data as a narrow stream from the host/DMA interface and packs consecutive beats into full-width kernel words of GROUP_NB*KER_WIDTH*DEPTH_NB bits. Tracks the memory write address so it can drive the memory's write-end configuration (wr_cfg_end/wr_cfg_set) once per layer load. It then streams the packed words into the memory's write port with a valid/ready handshake.

## Interface
- GROUP_NB, 4, convolution groups per kernel word
- KER_WIDTH, 16, bits per kernel coefficient
- DEPTH_NB, 16, coefficients per group
- UP_WIDTH, 64, upstream beat width; GROUP_NB*KER_WIDTH*DEPTH_NB must be an integer multiple of it
- MEM_AWIDTH, 16, kernel memory address width; memory depth is 1<<MEM_AWIDTH
- Derived: W = GROUP_NB*KER_WIDTH*DEPTH_NB; BEATS = W/UP_WIDTH (default 16)
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- cfg_words  in  MEM_AWIDTH  number of wide words in the next load (1..2^MEM_AWIDTH-1)
- cfg_set  in  1  one-cycle strobe that starts a load; sampled only in IDLE
- up_data  in  UP_WIDTH  upstream beat
- up_val  in  1  upstream valid
- up_rdy  out  1  upstream ready
- wr_data  out  W  packed kernel word to memory
- wr_data_val  out  1  packed word valid
- wr_data_rdy  in  1  memory ready
- wr_cfg_end  out  MEM_AWIDTH  last memory address of the current load
- wr_cfg_set  out  1  one-cycle strobe qualifying wr_cfg_end
- busy  out  1  high whenever state is not IDLE

## Operation
- Internal: wr_base (MEM_AWIDTH), word_cnt (MEM_AWIDTH), beat_cnt (log2 BEATS), pack register (W), output register (W).
- States: IDLE, CFG, LOAD, DRAIN.
- IDLE: cfg_set with cfg_words != 0 -> latch word count, go to CFG. cfg_words == 0 is ignored and the block stays in IDLE. cfg_set outside IDLE is ignored.
- CFG (exactly one cycle): wr_cfg_end <= wr_base + cfg_words - 1 (modulo 2^MEM_AWIDTH) and wr_cfg_set <= 1 for one cycle. wr_base <= wr_base + cfg_words (mod). Clear word_cnt and beat_cnt, then go to LOAD.
- LOAD: each beat with up_val & up_rdy is written into pack slice beat_cnt, bits [beat_cnt*UP_WIDTH +: UP_WIDTH], so the first beat lands in the LSBs. beat_cnt then increments.
  - On the beat where beat_cnt == BEATS-1, the completed word (pack register with the final beat merged) moves into the output register, wr_data_val sets, beat_cnt wraps to 0 and word_cnt increments.
  - When that word is the latched count, go to DRAIN.
- up_rdy = (state == LOAD) & ~(beat_cnt == BEATS-1 & wr_data_val & ~wr_data_rdy). Beats 0..BEATS-2 may therefore be accepted while the previous word is still stalled at the output.
- Output: wr_data_val clears on wr_data_val & wr_data_rdy unless a new word loads in the same cycle, in which case it stays high with the new data.
- While wr_data_val & ~wr_data_rdy, wr_data and wr_data_val hold stable.
- DRAIN: up_rdy = 0. When the output register empties (no valid word, or handshake this cycle), go to IDLE.
- wr_base persists across loads and wraps freely. It mirrors the memory's write pointer, which resets to 0 together with this block.

## Timing
- Reset values: up_rdy 0, wr_data_val 0, wr_data 0, wr_cfg_end 0, wr_cfg_set 0, busy 0, wr_base 0, state IDLE.
- Reset mid-load discards partial and pending words and clears wr_base.
- cfg_set at cycle t -> wr_cfg_set high at t+1 (CFG) -> up_rdy high at t+2.
- Last beat of a word accepted at cycle t -> wr_data_val high at t+1.
- Throughput: one beat per cycle sustained when wr_data_rdy is held high. No bubbles between words.
- busy rises the cycle after an accepted cfg_set. It falls the cycle after the final word handshake.

## Configuration
- KERNEL_PACK_MSB_FIRST_EN defined: beat k is placed at slice BEATS-1-k, so the first beat lands in the MSBs.
- KERNEL_PACK_MSB_FIRST_EN undefined: beat k is placed at slice k (LSB first). This is the default.
- Handshake, counts and timing are identical in both builds.

## Test plan
- Reset -> all outputs 0. Then cfg_words=3, cfg_set -> wr_cfg_set pulse with wr_cfg_end=2, and busy=1.
- Stream 48 beats with values 0..47 and wr_data_rdy=1 -> 3 words. Word0 slice k = k; words arrive 1 cycle after beats 15, 31 and 47. busy falls after word 2.
- Second load, cfg_words=2 -> wr_cfg_end=4 (wr_base continues from 3).
- Wrap case: drive wr_base to 65534, then cfg_words=4 -> wr_cfg_end=1, and wr_base becomes 2 afterwards.
- Hold wr_data_rdy=0 with a word pending -> 15 more beats accepted and up_rdy drops on beat 15. wr_data stays stable. Release -> no beat lost or duplicated.
- cfg_set during LOAD and cfg_words=0 in IDLE -> no wr_cfg_set pulse, no state change. Assert rst mid-word -> outputs 0. A new load then produces correct words from slice 0.
